// File: rtl/pix_frame_pkg.sv
// pix_frame_pkg: shared types and constants for the GMII pixel-frame generator
// and for the CRC32 engine it shares with the receive-side checker.
//   state_t     - generator FSM states, also driven out as a debug view
//   pat_mode_t  - payload pattern selector
//   lfsr_step   - one step of the payload LFSR
//   crc32_byte  - reflected CRC32 update for one byte, LSB first
package pix_frame_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        HDR  = 3'd3,
        PAY  = 3'd4,
        FCS  = 3'd5,
        IPG  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_INDEX  = 2'd0,
        MODE_CONST  = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_INDEX3 = 2'd3
    } pat_mode_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          HDR_LEN       = 8;

    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    // Residue in normal (non-reflected) bit order; the reflected register
    // holds the bit-reversed value 0xDEBB20E3 after a good frame plus FCS.
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    // x^8+x^6+x^5+x^4+1 as a right-shifting Fibonacci register: the feedback
    // taps sit at bits 0, 2, 3 and 4, and the new bit enters at bit 7.
    localparam logic [7:0]  LFSR_TAPS     = 8'h1D;
    localparam logic [7:0]  LFSR_SEED     = 8'hFF;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {^(s & LFSR_TAPS), s[7:1]};
    endfunction

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/pix_frame_gen_crc32_d8.sv
// crc32_d8: byte-wide reflected CRC32 (IEEE 802.3) register.
//   clk_i   - clock
//   rst_i   - synchronous reset, active-high; loads CRC_INIT
//   init_i  - load CRC_INIT (wins over en_i)
//   en_i    - fold data_i into the register
//   data_i  - byte to accumulate, processed LSB first
//   crc_o   - current register value (not inverted)
module crc32_d8
    import pix_frame_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = crc32_byte(crc_q, data_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/pix_frame_gen.sv
// pix_frame_gen: GMII byte-stream pixel-frame generator (BIST / loopback source).
// Emits preamble, SFD, 8-byte pixel header, patterned payload, optional FCS
// and an inter-packet gap, repeated for a burst of packets.
//   clk, rst            - clock, synchronous active-high reset
//   ce                  - byte strobe; GMII outputs and counters move only when 1
//   start, abort        - burst control
//   cfg_*               - burst configuration, latched when start is accepted
//   gmii_txd/tx_en/tx_er- registered GMII transmit byte stream
//   busy, done, aborted - burst status
//   dbg_state           - current FSM state
//
// Control handshake: start is taken only when the FSM is IDLE and busy is low;
// busy rises on that edge and stays high through the single-clk done pulse,
// dropping one clk after it. aborted is valid only while done is high.
module pix_frame_gen
    import pix_frame_pkg::*;
#(
    parameter int          BYTES_PER_PIX = 4,
    parameter int          PREAMBLE_LEN  = 7,
    parameter logic [15:0] RSVD_WORD     = 16'h0888,
    parameter int          MIN_IPG       = 12,
    parameter bit          CRC_EN        = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] cfg_row,
    input  logic [15:0] cfg_col,
    input  logic [15:0] cfg_len,
    input  logic [1:0]  cfg_mode,
    input  logic [7:0]  cfg_const,
    input  logic [7:0]  cfg_pkt_cnt,
    input  logic [7:0]  cfg_ipg,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output state_t      dbg_state
);

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [15:0] row_q;
    logic [15:0] col_q;
    logic [15:0] len_q;
    pat_mode_t   mode_q;
    logic [7:0]  const_q;
    logic [7:0]  pkt_left_q;
    logic [7:0]  ipg_q;
    logic [7:0]  lfsr_q;
    logic        abort_pend_q;
    logic        abort_flag_q;
    logic [7:0]  txd_q;
    logic        tx_en_q;
    logic        tx_er_q;
    logic        busy_q;
    logic        done_q;
    logic        aborted_q;

    logic [31:0] pay_total;
    logic [7:0]  hdr_byte;
    logic [7:0]  pay_byte;
    logic [7:0]  fcs_byte;
    logic [31:0] crc;
    logic [31:0] crc_inv;
    logic        abort_now;
    logic        crc_init_d;
    logic        crc_en_d;
    logic [7:0]  crc_data_d;
    state_t      post_pay_st;
    logic [7:0]  ipg_clamped;

    assign pay_total   = 32'(len_q) * 32'(BYTES_PER_PIX);
    assign post_pay_st = (CRC_EN != 1'b0) ? FCS : IPG;
    assign ipg_clamped = (cfg_ipg < 8'(MIN_IPG)) ? 8'(MIN_IPG) : cfg_ipg;
    // An abort seen on a non-strobe clk is remembered until the next byte slot.
    assign abort_now   = abort || abort_pend_q;
    assign crc_inv     = ~crc;

    always_comb begin
        hdr_byte = 8'h00;
        case (cnt_q[2:0])
            3'd0: hdr_byte = row_q[15:8];
            3'd1: hdr_byte = row_q[7:0];
            3'd2: hdr_byte = col_q[15:8];
            3'd3: hdr_byte = col_q[7:0];
            3'd4: hdr_byte = len_q[15:8];
            3'd5: hdr_byte = len_q[7:0];
            3'd6: hdr_byte = RSVD_WORD[15:8];
            3'd7: hdr_byte = RSVD_WORD[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        pay_byte = cnt_q[7:0];
        case (mode_q)
            MODE_CONST: pay_byte = const_q;
            MODE_LFSR:  pay_byte = lfsr_q;
            default:    pay_byte = cnt_q[7:0];
        endcase
    end

    // FCS goes out least-significant byte first.
    always_comb begin
        fcs_byte = crc_inv[7:0];
        case (cnt_q[1:0])
            2'd0: fcs_byte = crc_inv[7:0];
            2'd1: fcs_byte = crc_inv[15:8];
            2'd2: fcs_byte = crc_inv[23:16];
            2'd3: fcs_byte = crc_inv[31:24];
            default: fcs_byte = crc_inv[7:0];
        endcase
    end

    // CRC restarts while SFD goes out and accumulates header and payload only.
    always_comb begin
        crc_init_d = ce && (state_q == SFD);
        crc_en_d   = ce && !abort_now && ((state_q == HDR) || (state_q == PAY));
        crc_data_d = (state_q == HDR) ? hdr_byte : pay_byte;
    end

    crc32_d8 u_crc (
        .clk_i  (clk),
        .rst_i  (rst),
        .init_i (crc_init_d),
        .en_i   (crc_en_d),
        .data_i (crc_data_d),
        .crc_o  (crc)
    );

    // state_q/cnt_q name the next byte to emit; each strobe registers that
    // byte onto the GMII outputs and advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 32'd0;
            row_q        <= 16'd0;
            col_q        <= 16'd0;
            len_q        <= 16'd0;
            mode_q       <= MODE_INDEX;
            const_q      <= 8'd0;
            pkt_left_q   <= 8'd0;
            ipg_q        <= 8'd0;
            lfsr_q       <= LFSR_SEED;
            abort_pend_q <= 1'b0;
            abort_flag_q <= 1'b0;
            txd_q        <= 8'd0;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (done_q) begin
                busy_q <= 1'b0;
            end

            if (abort && !ce) begin
                if (state_q == IPG) begin
                    abort_flag_q <= 1'b1;
                end else if (state_q != IDLE) begin
                    abort_pend_q <= 1'b1;
                end
            end

            if (state_q == IDLE) begin
                if (start && !busy_q) begin
                    row_q        <= cfg_row;
                    col_q        <= cfg_col;
                    len_q        <= cfg_len;
                    mode_q       <= pat_mode_t'(cfg_mode);
                    const_q      <= cfg_const;
                    pkt_left_q   <= (cfg_pkt_cnt == 8'd0) ? 8'd1 : cfg_pkt_cnt;
                    ipg_q        <= ipg_clamped;
                    abort_pend_q <= 1'b0;
                    abort_flag_q <= 1'b0;
                    cnt_q        <= 32'd0;
                    busy_q       <= 1'b1;
                    state_q      <= PRE;
                end
            end else if (ce) begin
                if (state_q == IPG) begin
                    txd_q   <= 8'd0;
                    tx_en_q <= 1'b0;
                    tx_er_q <= 1'b0;
                    if (abort) begin
                        abort_flag_q <= 1'b1;
                    end
                    if (cnt_q == (32'(ipg_q) - 32'd1)) begin
                        cnt_q <= 32'd0;
                        if (abort_flag_q || abort || (pkt_left_q == 8'd1)) begin
                            state_q   <= IDLE;
                            done_q    <= 1'b1;
                            aborted_q <= abort_flag_q || abort;
                        end else begin
                            state_q    <= PRE;
                            row_q      <= row_q + 16'd1;
                            pkt_left_q <= pkt_left_q - 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end else if (abort_now) begin
                    // One error-marked byte, then the rest of the frame is dropped.
                    txd_q        <= 8'd0;
                    tx_en_q      <= 1'b1;
                    tx_er_q      <= 1'b1;
                    abort_flag_q <= 1'b1;
                    abort_pend_q <= 1'b0;
                    cnt_q        <= 32'd0;
                    state_q      <= IPG;
                end else begin
                    tx_en_q <= 1'b1;
                    tx_er_q <= 1'b0;
                    case (state_q)
                        PRE: begin
                            txd_q <= PREAMBLE_BYTE;
                            if (cnt_q == 32'(PREAMBLE_LEN - 1)) begin
                                cnt_q   <= 32'd0;
                                state_q <= SFD;
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        SFD: begin
                            txd_q   <= SFD_BYTE;
                            lfsr_q  <= LFSR_SEED;
                            cnt_q   <= 32'd0;
                            state_q <= HDR;
                        end
                        HDR: begin
                            txd_q <= hdr_byte;
                            if (cnt_q == 32'(HDR_LEN - 1)) begin
                                cnt_q   <= 32'd0;
                                state_q <= (pay_total != 32'd0) ? PAY : post_pay_st;
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        PAY: begin
                            txd_q  <= pay_byte;
                            lfsr_q <= lfsr_step(lfsr_q);
                            if (cnt_q == (pay_total - 32'd1)) begin
                                cnt_q   <= 32'd0;
                                state_q <= post_pay_st;
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        FCS: begin
                            txd_q <= fcs_byte;
                            if (cnt_q == 32'd3) begin
                                cnt_q   <= 32'd0;
                                state_q <= IPG;
                            end else begin
                                cnt_q <= cnt_q + 32'd1;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pix_frame_gen.sv
`timescale 1ns/1ps
module tb_pix_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        start;
    logic        abort;
    logic [15:0] cfg_row;
    logic [15:0] cfg_col;
    logic [15:0] cfg_len;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_const;
    logic [7:0]  cfg_pkt_cnt;
    logic [7:0]  cfg_ipg;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic        done;
    logic        aborted;
    pix_frame_pkg::state_t dbg_state;

    int          n_cmp = 0;
    int          n_err = 0;
    int          div = 1;
    int          hold_viol = 0;
    logic [7:0]  frm[$];
    int          er_cnt;
    int          gap;
    logic        gap_done;
    logic        cap_ok;

    logic [7:0]  exp1 [20] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                               8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h01, 8'h08, 8'h88,
                               8'h00, 8'h01, 8'h02, 8'h03};
    logic [7:0]  lfsr_exp [8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h87, 8'h43, 8'hA1};
    logic [15:0] burst_rows [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

    always #5 clk = ~clk;

    pix_frame_gen dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .start       (start),
        .abort       (abort),
        .cfg_row     (cfg_row),
        .cfg_col     (cfg_col),
        .cfg_len     (cfg_len),
        .cfg_mode    (cfg_mode),
        .cfg_const   (cfg_const),
        .cfg_pkt_cnt (cfg_pkt_cnt),
        .cfg_ipg     (cfg_ipg),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One GMII byte slot: div-1 idle clks with ce low, then one strobe clk.
    task automatic do_byte();
        logic [7:0] h_d;
        logic       h_en;
        logic       h_er;
        h_d  = gmii_txd;
        h_en = gmii_tx_en;
        h_er = gmii_tx_er;
        for (int i = 1; i < div; i++) begin
            ce = 1'b0;
            @(posedge clk);
            #1;
            if (gmii_txd !== h_d || gmii_tx_en !== h_en || gmii_tx_er !== h_er) begin
                hold_viol++;
            end
        end
        ce = 1'b1;
        @(posedge clk);
        #1;
        if (div > 1) ce = 1'b0;
    endtask

    task automatic start_burst(input logic [15:0] row, input logic [15:0] col,
                               input logic [15:0] len, input logic [1:0] mode,
                               input logic [7:0] cst, input logic [7:0] pkt,
                               input logic [7:0] ipg);
        cfg_row     = row;
        cfg_col     = col;
        cfg_len     = len;
        cfg_mode    = mode;
        cfg_const   = cst;
        cfg_pkt_cnt = pkt;
        cfg_ipg     = ipg;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
    endtask

    // Collects one frame (current byte included) into frm; ends on the first idle byte.
    task automatic capture_frame();
        int guard;
        guard  = 0;
        er_cnt = 0;
        frm.delete();
        while (!gmii_tx_en && guard < 400) begin
            do_byte();
            guard++;
        end
        cap_ok = gmii_tx_en;
        while (gmii_tx_en && guard < 2000) begin
            frm.push_back(gmii_txd);
            if (gmii_tx_er) er_cnt++;
            do_byte();
            guard++;
        end
    endtask

    // Counts idle bytes, starting with the current one, until tx_en or done.
    task automatic measure_gap();
        gap      = 0;
        gap_done = 1'b0;
        while (!gmii_tx_en && gap < 200) begin
            gap++;
            if (done) begin
                gap_done = 1'b1;
                break;
            end
            do_byte();
        end
    endtask

    function automatic logic [31:0] crc_bit_serial(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ d[b];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    // CRC over header..FCS of the captured frame, returned in normal bit order.
    function automatic logic [31:0] frame_residue();
        logic [31:0] c;
        logic [31:0] r;
        c = 32'hFFFFFFFF;
        for (int i = 8; i < frm.size(); i++) begin
            c = crc_bit_serial(c, frm[i]);
        end
        r = {<<{c}};
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ce = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_row = 16'd0; cfg_col = 16'd0; cfg_len = 16'd0; cfg_mode = 2'd0;
        cfg_const = 8'd0; cfg_pkt_cnt = 8'd0; cfg_ipg = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", gmii_txd, 8'h00);
        check("rst_en", gmii_tx_en, 1'b0);
        check("rst_er", gmii_tx_er, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_aborted", aborted, 1'b0);
        check("rst_state", dbg_state, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // len=1 frame, full layout and FCS residue, gap and done timing
        start_burst(16'h0102, 16'h0304, 16'd1, 2'd0, 8'h00, 8'd1, 8'd0);
        check("t1_busy_on_start", busy, 1'b1);
        check("t1_en_on_start", gmii_tx_en, 1'b0);
        do_byte();
        check("t1_first_byte", {gmii_tx_en, gmii_txd}, 9'h155);
        capture_frame();
        check("t1_frame_seen", cap_ok, 1'b1);
        check("t1_len", frm.size(), 24);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t1_byte%0d", i), frm[i], exp1[i]);
        end
        check("t1_er", er_cnt, 0);
        check("t1_residue", frame_residue(), 32'hC704DD7B);
        measure_gap();
        check("t1_gap", gap, 12);
        check("t1_done", gap_done, 1'b1);
        check("t1_aborted", aborted, 1'b0);
        @(posedge clk);
        #1;
        check("t1_done_pulse", done, 1'b0);
        check("t1_busy_low", busy, 1'b0);

        // empty payload
        start_burst(16'h0010, 16'h0020, 16'd0, 2'd0, 8'h00, 8'd1, 8'd0);
        capture_frame();
        check("t2_len", frm.size(), 20);
        check("t2_len_hi", frm[12], 8'h00);
        check("t2_len_lo", frm[13], 8'h00);
        check("t2_rsvd_hi", frm[14], 8'h08);
        check("t2_rsvd_lo", frm[15], 8'h88);
        check("t2_residue", frame_residue(), 32'hC704DD7B);
        measure_gap();
        check("t2_gap", gap, 12);
        check("t2_done", gap_done, 1'b1);
        @(posedge clk);
        #1;

        // len=100: index pattern wraps at byte 256
        start_burst(16'h0001, 16'h0002, 16'd100, 2'd3, 8'h00, 8'd0, 8'd20);
        capture_frame();
        check("t3_len", frm.size(), 420);
        check("t3_pay255", frm[16 + 255], 8'hFF);
        check("t3_pay256", frm[16 + 256], 8'h00);
        check("t3_pay399", frm[16 + 399], 8'h8F);
        check("t3_residue", frame_residue(), 32'hC704DD7B);
        measure_gap();
        check("t3_gap", gap, 20);
        check("t3_done", gap_done, 1'b1);
        @(posedge clk);
        #1;

        // burst of three with row wrap and clamped gap
        start_burst(16'hFFFE, 16'h0005, 16'd1, 2'd0, 8'h00, 8'd3, 8'd5);
        for (int p = 0; p < 3; p++) begin
            capture_frame();
            check($sformatf("t4_len_p%0d", p), frm.size(), 24);
            check($sformatf("t4_row_hi_p%0d", p), frm[8], burst_rows[p][15:8]);
            check($sformatf("t4_row_lo_p%0d", p), frm[9], burst_rows[p][7:0]);
            check($sformatf("t4_residue_p%0d", p), frame_residue(), 32'hC704DD7B);
            measure_gap();
            check($sformatf("t4_gap_p%0d", p), gap, 12);
            check($sformatf("t4_done_p%0d", p), gap_done, (p == 2));
        end
        check("t4_busy_at_done", busy, 1'b1);
        @(posedge clk);
        #1;
        check("t4_busy_low", busy, 1'b0);
        check("t4_done_low", done, 1'b0);

        // LFSR payload at full rate, then with a 1-in-10 strobe
        start_burst(16'h0007, 16'h0008, 16'd2, 2'd2, 8'h00, 8'd1, 8'd0);
        capture_frame();
        check("t5a_len", frm.size(), 28);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t5a_pay%0d", k), frm[16 + k], lfsr_exp[k]);
        end
        check("t5a_residue", frame_residue(), 32'hC704DD7B);
        measure_gap();
        check("t5a_done", gap_done, 1'b1);
        @(posedge clk);
        #1;
        div = 10;
        ce = 1'b0;
        hold_viol = 0;
        start_burst(16'h0007, 16'h0008, 16'd2, 2'd2, 8'h00, 8'd1, 8'd0);
        capture_frame();
        check("t5b_len", frm.size(), 28);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t5b_pay%0d", k), frm[16 + k], lfsr_exp[k]);
        end
        check("t5b_row_lo", frm[9], 8'h07);
        check("t5b_residue", frame_residue(), 32'hC704DD7B);
        measure_gap();
        check("t5b_gap", gap, 12);
        check("t5b_done", gap_done, 1'b1);
        check("t5b_hold", hold_viol, 0);
        @(posedge clk);
        #1;
        check("t5b_busy_low", busy, 1'b0);
        div = 1;
        ce = 1'b1;

        // abort at the third payload byte; a start during the frame is ignored
        start_burst(16'h0100, 16'h0200, 16'd4, 2'd0, 8'h00, 8'd2, 8'd0);
        frm.delete();
        for (int g = 0; g < 20 && !gmii_tx_en; g++) do_byte();
        check("t6_frame_seen", gmii_tx_en, 1'b1);
        frm.push_back(gmii_txd);
        for (int i = 1; i <= 18; i++) begin
            if (i == 3) begin
                cfg_row = 16'hAAAA;
                start = 1'b1;
            end
            do_byte();
            start = 1'b0;
            frm.push_back(gmii_txd);
        end
        check("t6_row_hi", frm[8], 8'h01);
        check("t6_row_lo", frm[9], 8'h00);
        check("t6_pay0", frm[16], 8'h00);
        check("t6_pay1", frm[17], 8'h01);
        check("t6_pay2", frm[18], 8'h02);
        check("t6_busy", busy, 1'b1);
        abort = 1'b1;
        do_byte();
        abort = 1'b0;
        check("t6_err_en", gmii_tx_en, 1'b1);
        check("t6_err_er", gmii_tx_er, 1'b1);
        check("t6_err_txd", gmii_txd, 8'h00);
        do_byte();
        check("t6_after_en", gmii_tx_en, 1'b0);
        check("t6_after_er", gmii_tx_er, 1'b0);
        measure_gap();
        check("t6_gap", gap, 12);
        check("t6_done", gap_done, 1'b1);
        check("t6_aborted", aborted, 1'b1);
        @(posedge clk);
        #1;
        check("t6_busy_low", busy, 1'b0);
        check("t6_aborted_low", aborted, 1'b0);

        // reset in the header, then a clean constant-pattern frame
        start_burst(16'h1111, 16'h2222, 16'd2, 2'd0, 8'h00, 8'd1, 8'd0);
        check("t7_busy_restart", busy, 1'b1);
        for (int g = 0; g < 20 && !gmii_tx_en; g++) do_byte();
        for (int i = 0; i < 10; i++) do_byte();
        check("t7_in_hdr_en", gmii_tx_en, 1'b1);
        check("t7_in_hdr_txd", gmii_txd, 8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t7_rst_txd", gmii_txd, 8'h00);
        check("t7_rst_en", gmii_tx_en, 1'b0);
        check("t7_rst_er", gmii_tx_er, 1'b0);
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_done", done, 1'b0);
        check("t7_rst_aborted", aborted, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_burst(16'h0003, 16'h0004, 16'd2, 2'd1, 8'hA5, 8'd1, 8'd0);
        capture_frame();
        check("t7_len", frm.size(), 28);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t7_pay%0d", k), frm[16 + k], 8'hA5);
        end
        check("t7_er", er_cnt, 0);
        check("t7_residue", frame_residue(), 32'hC704DD7B);
        measure_gap();
        check("t7_done", gap_done, 1'b1);
        check("t7_aborted", aborted, 1'b0);
        @(posedge clk);
        #1;
        check("t7_busy_low", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
